// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline: tracks EX/MEM/WB
// destinations, selects forwarded EX operands and raises load-use / RAW stalls.
module fwd_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 2,
    parameter int FWD_EN   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        freeze_i,
    input  logic                        id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]          id_src_vld_i,
    input  logic [REG_AW-1:0]           id_dst_i,
    input  logic                        id_wen_i,
    input  logic                        id_load_i,
    input  logic [NUM_SRC*DATA_W-1:0]   rf_data_i,
    input  logic [DATA_W-1:0]           exmem_data_i,
    input  logic [DATA_W-1:0]           memwb_data_i,
    output logic [NUM_SRC*DATA_W-1:0]   ex_op_o,
    output logic [NUM_SRC*2-1:0]        ex_fwd_sel_o,
    output logic                        ex_valid_o,
    output logic                        stall_o
);

    localparam logic FWD_ON  = (FWD_EN != 32'sd0);
    localparam logic ZERO_ON = (ZERO_REG != 32'sd0);

    // EX slot
    logic                      ex_valid_r;
    logic [NUM_SRC*REG_AW-1:0] ex_src_r;
    logic [NUM_SRC-1:0]        ex_src_vld_r;
    logic [REG_AW-1:0]         ex_dst_r;
    logic                      ex_wen_r;
    logic                      ex_load_r;
    // MEM and WB slots only need to identify their producer
    logic                      mem_valid_r;
    logic [REG_AW-1:0]         mem_dst_r;
    logic                      mem_wen_r;
    logic                      wb_valid_r;
    logic [REG_AW-1:0]         wb_dst_r;
    logic                      wb_wen_r;

    logic                      issue_s;
    logic                      hazard_s;
    logic                      ex_hit_s;
    logic                      mem_hit_s;
    logic                      raw_hit_s;
    logic [REG_AW-1:0]         id_a_s;
    logic [REG_AW-1:0]         ex_a_s;
    logic                      use_s;

    // A slot produces register a only if it is live, writes, and a is not the zero register.
    function automatic logic slot_match(
        input logic              vld,
        input logic              wen,
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] a
    );
        logic zero_s;
        zero_s = ZERO_ON & (a == {REG_AW{1'b0}});
        return vld & wen & (dst == a) & ~zero_s;
    endfunction

    assign issue_s    = id_valid_i & ~stall_o & ~freeze_i;
    assign ex_valid_o = ex_valid_r;

    // Stall decision for the instruction currently in ID.
    always_comb begin
        hazard_s  = 1'b0;
        id_a_s    = {REG_AW{1'b0}};
        ex_hit_s  = 1'b0;
        mem_hit_s = 1'b0;
        raw_hit_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            id_a_s    = id_src_i[k*REG_AW +: REG_AW];
            ex_hit_s  = slot_match(ex_valid_r, ex_wen_r, ex_dst_r, id_a_s);
            mem_hit_s = slot_match(mem_valid_r, mem_wen_r, mem_dst_r, id_a_s);
            // With forwarding only a load in EX cannot be bypassed in time.
            if (FWD_ON) begin
                raw_hit_s = ex_hit_s & ex_load_r;
            end else begin
                raw_hit_s = ex_hit_s | mem_hit_s;
            end
            if (id_src_vld_i[k] && raw_hit_s) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        stall_o = id_valid_i & hazard_s;
    end

    // Per-operand forwarding select and operand mux for the EX instruction.
    always_comb begin
        ex_fwd_sel_o = {(NUM_SRC*2){1'b0}};
        ex_op_o      = rf_data_i;
        ex_a_s       = {REG_AW{1'b0}};
        use_s        = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            ex_a_s = ex_src_r[k*REG_AW +: REG_AW];
            use_s  = FWD_ON & ex_valid_r & ex_src_vld_r[k];
            // MEM is checked first so the youngest producer wins.
            if (use_s && slot_match(mem_valid_r, mem_wen_r, mem_dst_r, ex_a_s)) begin
                ex_fwd_sel_o[k*2 +: 2]   = 2'b01;
                ex_op_o[k*DATA_W +: DATA_W] = exmem_data_i;
            end else if (use_s && slot_match(wb_valid_r, wb_wen_r, wb_dst_r, ex_a_s)) begin
                ex_fwd_sel_o[k*2 +: 2]   = 2'b10;
                ex_op_o[k*DATA_W +: DATA_W] = memwb_data_i;
            end else begin
                ex_fwd_sel_o[k*2 +: 2]   = 2'b00;
                ex_op_o[k*DATA_W +: DATA_W] = rf_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Slot pipeline: freeze holds everything, otherwise shift and load ID (bubble on stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r   <= 1'b0;
            ex_src_r     <= {(NUM_SRC*REG_AW){1'b0}};
            ex_src_vld_r <= {NUM_SRC{1'b0}};
            ex_dst_r     <= {REG_AW{1'b0}};
            ex_wen_r     <= 1'b0;
            ex_load_r    <= 1'b0;
            mem_valid_r  <= 1'b0;
            mem_dst_r    <= {REG_AW{1'b0}};
            mem_wen_r    <= 1'b0;
            wb_valid_r   <= 1'b0;
            wb_dst_r     <= {REG_AW{1'b0}};
            wb_wen_r     <= 1'b0;
        end else if (!freeze_i) begin
            wb_valid_r   <= mem_valid_r;
            wb_dst_r     <= mem_dst_r;
            wb_wen_r     <= mem_wen_r;
            mem_valid_r  <= ex_valid_r;
            mem_dst_r    <= ex_dst_r;
            mem_wen_r    <= ex_wen_r;
            ex_valid_r   <= issue_s;
            ex_src_r     <= id_src_i;
            ex_src_vld_r <= id_src_vld_i;
            ex_dst_r     <= id_dst_i;
            ex_wen_r     <= id_wen_i;
            ex_load_r    <= id_load_i;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed bench for fwd_hazard_unit: one forwarding instance and
// one interlock-only instance, both checked against an age-indexed in-flight model.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst, freeze, id_valid, id_wen, id_load;
    logic [7:0]  id_src;
    logic [1:0]  id_src_vld;
    logic [3:0]  id_dst;
    logic [31:0] rf_data;
    logic [15:0] exmem, memwb;

    logic [31:0] op_f, op_i;
    logic [3:0]  sel_f, sel_i;
    logic        exv_f, exv_i, stall_f, stall_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.DATA_W(16), .REG_AW(4), .NUM_SRC(2), .FWD_EN(1), .ZERO_REG(1)) u_fwd (
        .clk(clk), .rst(rst), .freeze_i(freeze), .id_valid_i(id_valid), .id_src_i(id_src),
        .id_src_vld_i(id_src_vld), .id_dst_i(id_dst), .id_wen_i(id_wen), .id_load_i(id_load),
        .rf_data_i(rf_data), .exmem_data_i(exmem), .memwb_data_i(memwb),
        .ex_op_o(op_f), .ex_fwd_sel_o(sel_f), .ex_valid_o(exv_f), .stall_o(stall_f));

    fwd_hazard_unit #(.DATA_W(16), .REG_AW(4), .NUM_SRC(2), .FWD_EN(0), .ZERO_REG(1)) u_ilk (
        .clk(clk), .rst(rst), .freeze_i(freeze), .id_valid_i(id_valid), .id_src_i(id_src),
        .id_src_vld_i(id_src_vld), .id_dst_i(id_dst), .id_wen_i(id_wen), .id_load_i(id_load),
        .rf_data_i(rf_data), .exmem_data_i(exmem), .memwb_data_i(memwb),
        .ex_op_o(op_i), .ex_fwd_sel_o(sel_i), .ex_valid_o(exv_i), .stall_o(stall_i));

    // Reference model: per configuration, the in-flight instructions by age
    // (0 = in EX, 1 = in MEM, 2 = in WB); config 0 forwards, config 1 interlocks.
    typedef struct {
        bit       valid;
        bit [3:0] dst;
        bit       wen;
        bit       load;
        bit [3:0] src0;
        bit [3:0] src1;
        bit [1:0] svld;
    } inst_t;

    inst_t pipe_q [2][3];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(inst_t p, bit [3:0] a);
        return p.valid && p.wen && (p.dst == a) && (a != 4'd0);
    endfunction

    function automatic bit exp_stall(int c);
        bit hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit [3:0] a = (k == 1) ? id_src[7:4] : id_src[3:0];
            if (id_src_vld[k]) begin
                if (c == 0) hit |= writes(pipe_q[c][0], a) && pipe_q[c][0].load;
                else        hit |= writes(pipe_q[c][0], a) || writes(pipe_q[c][1], a);
            end
        end
        return id_valid && hit;
    endfunction

    function automatic bit [1:0] exp_sel(int c, int k);
        inst_t e = pipe_q[c][0];
        bit [3:0] a = (k == 1) ? e.src1 : e.src0;
        if (c != 0 || !e.valid || !e.svld[k]) return 2'b00;
        if (writes(pipe_q[c][1], a)) return 2'b01;
        if (writes(pipe_q[c][2], a)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            logic [3:0]  es;
            logic [31:0] eo;
            for (int k = 0; k < 2; k++) begin
                bit [1:0] s = exp_sel(c, k);
                es[2*k +: 2]  = s;
                eo[16*k +: 16] = (s == 2'b01) ? exmem : (s == 2'b10) ? memwb : rf_data[16*k +: 16];
            end
            chk_eq(c == 0 ? "fwd_stall" : "ilk_stall", c == 0 ? stall_f : stall_i, 32'(exp_stall(c)));
            chk_eq(c == 0 ? "fwd_exv"   : "ilk_exv",   c == 0 ? exv_f   : exv_i,   32'(pipe_q[c][0].valid));
            chk_eq(c == 0 ? "fwd_sel"   : "ilk_sel",   c == 0 ? sel_f   : sel_i,   32'(es));
            chk_eq(c == 0 ? "fwd_op"    : "ilk_op",    c == 0 ? op_f    : op_i,    eo);
        end
    endtask

    // One clock: optionally check, advance the model on the edge, return at the falling edge.
    task automatic tick(input bit do_chk);
        bit    st [2];
        inst_t nw;
        #1;
        if (do_chk) check_all();
        for (int c = 0; c < 2; c++) st[c] = exp_stall(c);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int a = 0; a < 3; a++) pipe_q[c][a].valid = 1'b0;
            end else if (!freeze) begin
                pipe_q[c][2] = pipe_q[c][1];
                pipe_q[c][1] = pipe_q[c][0];
                nw.valid = id_valid && !st[c];
                nw.dst   = id_dst;
                nw.wen   = id_wen;
                nw.load  = id_load;
                nw.src0  = id_src[3:0];
                nw.src1  = id_src[7:4];
                nw.svld  = id_src_vld;
                pipe_q[c][0] = nw;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit [3:0] s0, input bit [3:0] s1, input bit [1:0] sv,
                         input bit [3:0] d, input bit w, input bit ld);
        id_valid   = v;
        id_src     = {s1, s0};
        id_src_vld = sv;
        id_dst     = d;
        id_wen     = w;
        id_load    = ld;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    initial begin
        freeze  = 1'b0;
        rst     = 1'b1;
        rf_data = $urandom;
        exmem   = 16'h1234;
        memwb   = 16'hBEEF;
        drive(1'b1, 4'($urandom), 4'($urandom), 2'b11, 4'($urandom), 1'b1, 1'b1);
        @(negedge clk);
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        #1;
        chk_eq("rst_exv",   {exv_i, exv_f}, 32'd0);
        chk_eq("rst_stall", {stall_i, stall_f}, 32'd0);
        chk_eq("rst_sel",   {sel_i, sel_f}, 32'd0);
        chk_eq("rst_op",    op_f, rf_data);
        idle(3);

        // ADD R3 ; SUB R4,R3,R5 -> EX-to-EX forward
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0); tick(1'b1);
        drive(1'b1, 4'd3, 4'd5, 2'b11, 4'd4, 1'b1, 1'b0); #1;
        chk_eq("t2_nostall", stall_f, 32'd0); tick(1'b1);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0); #1;
        chk_eq("t2_sel", sel_f[1:0], 32'd1);
        chk_eq("t2_op0", op_f[15:0], 32'h1234);
        idle(4);

        // LW R2 ; ADD R6,R2,R2 -> single bubble, then both operands from WB
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1); tick(1'b1);
        drive(1'b1, 4'd2, 4'd2, 2'b11, 4'd6, 1'b1, 1'b0); #1;
        chk_eq("t4_stall1", stall_f, 32'd1); tick(1'b1);
        chk_eq("t4_stall2", stall_f, 32'd0);
        chk_eq("t4_bubble", exv_f, 32'd0); tick(1'b1);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0); #1;
        chk_eq("t4_exv", exv_f, 32'd1);
        chk_eq("t4_sel", sel_f, 32'hA);
        chk_eq("t4_op",  op_f, {memwb, memwb});
        idle(4);

        // Load to R0 then read R0: never a hazard in either mode
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1); tick(1'b1);
        drive(1'b1, 4'd0, 4'd0, 2'b11, 4'd7, 1'b1, 1'b0); #1;
        chk_eq("t5_stall", {stall_i, stall_f}, 32'd0); tick(1'b1);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0); #1;
        chk_eq("t5_sel", sel_f, 32'd0);
        idle(4);

        // Interlock: ADD R3 ; consumer -> two stall cycles, frozen cycle in between
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0); tick(1'b1);
        drive(1'b1, 4'd3, 4'd1, 2'b01, 4'd5, 1'b1, 1'b0); #1;
        chk_eq("t6_stall_a", stall_i, 32'd1); tick(1'b1);
        freeze = 1'b1; #1;
        chk_eq("t6_stall_frz", stall_i, 32'd1); tick(1'b1);
        freeze = 1'b0; #1;
        chk_eq("t6_stall_b", stall_i, 32'd1); tick(1'b1);
        chk_eq("t6_release", stall_i, 32'd0); tick(1'b1);
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0); #1;
        chk_eq("t6_exv", exv_i, 32'd1);
        chk_eq("t6_sel", sel_i, 32'd0);
        idle(3);

        // Random traffic over a small register window to provoke every hazard kind.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            freeze  = ($urandom_range(0, 7) == 0);
            rf_data = $urandom;
            exmem   = 16'($urandom);
            memwb   = 16'($urandom);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  2'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            tick(1'b1);
        end
        rst = 1'b0;
        freeze = 1'b0;
        tick(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
